// File: rtl/airi5c_jtag_master.sv
// airi5c_jtag_master: command-driven JTAG sequencer (TAP reset, IR/DR scan, idle TCK).
// Generates tck/tms/tdi from the system clock and returns captured tdo bits per command.
// Optional build macro AIRI5C_JTAG_MASTER_RTI_PAD_EN appends RTI_CYCLES Run-Test/Idle
// TCKs after every IR/DR scan.
`timescale 1ns/1ps

module airi5c_jtag_master #(
  parameter int unsigned IR_WIDTH   = 5,
  parameter int unsigned DR_WIDTH   = 41,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned RTI_CYCLES = 4,
  parameter int unsigned LW         = $clog2(DR_WIDTH + 1)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [LW-1:0]       cmd_len,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

`ifdef AIRI5C_JTAG_MASTER_RTI_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam int unsigned PAD_TCK = PAD_EN ? RTI_CYCLES : 0;

  localparam int unsigned CW  = 16;
  localparam int unsigned IW  = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam int unsigned DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] OP_RST  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_DR   = 2'b10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TRST  = 3'd1;
  localparam logic [2:0] S_SEL   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_EXIT  = 3'd4;
  localparam logic [2:0] S_PAD   = 3'd5;
  localparam logic [2:0] S_WAIT  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [DVW-1:0]      r_div;
  logic [1:0]          r_op;
  logic [CW-1:0]       r_len;
  logic [DR_WIDTH-1:0] r_data;
  logic [DR_WIDTH-1:0] r_cap;
  logic [DR_WIDTH-1:0] r_rsp_data;
  logic                r_rsp_valid;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                r_tck;
  logic                r_tms;
  logic                r_tdi;

  logic [2:0]          w_state_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [CW-1:0]       w_last;
  logic [CW-1:0]       w_dr_len;
  logic [1:0]          w_op;
  logic                w_is_ir;
  logic                w_tck_st;
  logic                w_tick;
  logic                w_rise;
  logic                w_fall;
  logic                w_accept;
  logic                w_tms_nxt;
  logic                w_tdi_nxt;

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;
  assign tck       = r_tck;
  assign tms       = r_tms;
  assign tdi       = r_tdi;

  // TCK timing: half-period tick, rising and falling TCK events
  assign w_tck_st = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_tick   = (r_div == DVW'(CLK_DIV - 1));
  assign w_rise   = w_tck_st & w_tick & ~r_tck;
  assign w_fall   = w_tck_st & w_tick & r_tck;
  assign w_accept = r_cmd_ready & cmd_valid;

  // Command decode: op is taken from the bus while idle, else from the latch
  assign w_op     = (r_state == S_IDLE) ? cmd_op : r_op;
  assign w_is_ir  = (w_op == OP_IR);
  assign w_dr_len = ((cmd_len == '0) || (cmd_len > LW'(DR_WIDTH))) ? CW'(DR_WIDTH) : CW'(cmd_len);

  // Index of the last TCK spent in the current state
  always_comb begin
    w_last = '0;
    case (r_state)
      S_TRST:          w_last = CW'(5);
      S_SEL:           w_last = w_is_ir ? CW'(3) : CW'(2);
      S_SHIFT, S_WAIT: w_last = r_len - CW'(1);
      S_EXIT:          w_last = CW'(1);
      S_PAD:           w_last = CW'(PAD_TCK - 1);
      default:         w_last = '0;
    endcase
  end

  // Next state and TCK index; TCK states advance on the falling TCK edge
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = '0;
          case (cmd_op)
            OP_RST:       w_state_nxt = S_TRST;
            OP_IR, OP_DR: w_state_nxt = S_SEL;
            default:      w_state_nxt = (cmd_len == '0) ? S_DONE : S_WAIT;
          endcase
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: begin
        if (w_fall) begin
          if (r_cnt == w_last) begin
            w_cnt_nxt = '0;
            case (r_state)
              S_SEL:   w_state_nxt = S_SHIFT;
              S_SHIFT: w_state_nxt = S_EXIT;
              S_EXIT:  w_state_nxt = (PAD_TCK != 0) ? S_PAD : S_DONE;
              default: w_state_nxt = S_DONE;
            endcase
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
    endcase
  end

  // TMS/TDI for the TCK about to be generated, derived from the next position
  always_comb begin
    w_tms_nxt = r_tms;
    w_tdi_nxt = 1'b0;
    case (w_state_nxt)
      S_TRST:  w_tms_nxt = (w_cnt_nxt != CW'(5));
      S_SEL:   w_tms_nxt = w_is_ir ? (w_cnt_nxt < CW'(2)) : (w_cnt_nxt == '0);
      S_SHIFT: begin
        w_tms_nxt = (w_cnt_nxt == (r_len - CW'(1)));
        w_tdi_nxt = r_data[w_cnt_nxt[IW-1:0]];
      end
      S_EXIT:  w_tms_nxt = (w_cnt_nxt == '0);
      S_PAD, S_WAIT: w_tms_nxt = 1'b0;
      default: w_tms_nxt = r_tms;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Datapath: command latch, TCK divider, TDO capture, registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_div       <= '0;
      r_op        <= OP_RST;
      r_len       <= '0;
      r_data      <= '0;
      r_cap       <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
    end else begin
      r_cmd_ready <= (r_state == S_IDLE) && !w_accept;
      r_busy      <= (w_state_nxt != S_IDLE) || (r_state == S_DONE);
      r_rsp_valid <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_rsp_data <= ((r_op == OP_IR) || (r_op == OP_DR)) ? r_cap : '0;
      end
      if (w_accept) begin
        r_op   <= cmd_op;
        r_data <= cmd_data;
        r_cap  <= '0;
        case (cmd_op)
          OP_IR:   r_len <= CW'(IR_WIDTH);
          OP_DR:   r_len <= w_dr_len;
          default: r_len <= CW'(cmd_len);
        endcase
      end
      if (w_tck_st) begin
        r_div <= w_tick ? '0 : (r_div + DVW'(1));
        if (w_tick) r_tck <= ~r_tck;
      end else begin
        r_div <= '0;
        r_tck <= 1'b0;
      end
      if (w_rise && (r_state == S_SHIFT)) begin
        r_cap[r_cnt[IW-1:0]] <= tdo;
      end
      if (w_accept || w_fall) begin
        r_tms <= w_tms_nxt;
        r_tdi <= w_tdi_nxt;
      end
    end
  end

endmodule
